pwm_fade_ctrl: RTL and testbench

Duty-cycle sequencer for the `pwm` block: produces the `dutyCycle` word that drives a pwm instance, stepping it through a programmable fade envelope: ramp up, hold high, ramp down, hold low. The envelope advances on single-cycle step ticks, normally the `dividedPulse` output of a `clkDivHz` instance. Arithmetic is saturating, so duty never wraps. Start/stop control is level-safe, and a completion pulse is provided for sequencing several LEDs.

---
 rtl/pwm_fade_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: duty-cycle sequencer for a pwm instance.
// Steps dutyCycle through a fade envelope on step ticks:
// ramp up, hold high, ramp down, hold low. Ramps saturate at the plateau levels.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enable                   0 freezes the block (ticks and start ignored)
//   stepPulse                envelope tick strobe (counted each cycle high while enabled)
//   start, stop, loop        sequencing control
//   minDuty, maxDuty         envelope levels, latched at start
//   stepSize, holdTicks      ramp increment and plateau length, latched at start
//   dutyCycle                registered duty word to the pwm
//   busy                     high whenever not IDLE
//   cycleDone                one-clk pulse after each completed cycle
//   state                    debug encoding of the FSM state
module pwm_fade_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             stepPulse,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [WIDTH-1:0] minDuty,
  input  logic [WIDTH-1:0] maxDuty,
  input  logic [WIDTH-1:0] stepSize,
  input  logic [7:0]       holdTicks,
  output logic [WIDTH-1:0] dutyCycle,
  output logic             busy,
  output logic             cycleDone,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  state_t           cur_state, nxt_state;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] lo_q, hi_q, step_q;
  logic [7:0]       hold_q, hold_cnt_q, hold_cnt_d;
  logic             busy_q, done_q, done_d;
  logic             stop_pend_q, stop_pend_d;
  logic             latch_cfg, cycle_end, tick;
  logic [WIDTH:0]   up_res, down_res;

  // Saturating ramp step toward hi: MSB flags that the plateau was reached.
  // The sum is formed one bit wider so it can never wrap.
  function automatic logic [WIDTH:0] sat_step_up(input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] h);
    logic [WIDTH:0] sum;
    sum = {1'b0, d} + {1'b0, s};
    if (sum >= {1'b0, h}) return {1'b1, h};
    return {1'b0, sum[WIDTH-1:0]};
  endfunction

  // Saturating ramp step toward lo; d never drops below l, so d-l cannot wrap.
  function automatic logic [WIDTH:0] sat_step_down(input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] l);
    if ((d - l) <= s) return {1'b1, l};
    return {1'b0, d - s};
  endfunction

  assign tick     = enable & stepPulse;
  assign up_res   = sat_step_up(duty_q, step_q, hi_q);
  assign down_res = sat_step_down(duty_q, step_q, lo_q);

  always_comb begin
    nxt_state   = cur_state;
    duty_d      = duty_q;
    hold_cnt_d  = hold_cnt_q;
    done_d      = 1'b0;
    latch_cfg   = 1'b0;
    cycle_end   = 1'b0;
    // A stop seen at any point while busy is remembered until the cycle ends.
    stop_pend_d = stop_pend_q | (stop & (cur_state != IDLE));

    case (cur_state)
      IDLE: begin
        if (enable && start) begin
          latch_cfg   = 1'b1;
          duty_d      = minDuty;
          nxt_state   = RAMP_UP;
          stop_pend_d = stop;
        end
      end
      RAMP_UP: begin
        if (tick) begin
          duty_d = up_res[WIDTH-1:0];
          if (up_res[WIDTH]) begin
            if (hold_q == 8'd0) begin
              nxt_state = RAMP_DOWN;
            end else begin
              nxt_state  = HOLD_HIGH;
              hold_cnt_d = hold_q;
            end
          end
        end
      end
      HOLD_HIGH: begin
        if (tick) begin
          if (hold_cnt_q == 8'd1) nxt_state = RAMP_DOWN;
          else                    hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          duty_d = down_res[WIDTH-1:0];
          if (down_res[WIDTH]) begin
            if (hold_q == 8'd0) begin
              cycle_end = 1'b1;
            end else begin
              nxt_state  = HOLD_LOW;
              hold_cnt_d = hold_q;
            end
          end
        end
      end
      HOLD_LOW: begin
        if (tick) begin
          if (hold_cnt_q == 8'd1) cycle_end = 1'b1;
          else                    hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    // The live stop input is checked too, so a stop on the final tick still wins.
    if (cycle_end) begin
      done_d = 1'b1;
      if (loop && !stop_pend_q && !stop) begin
        nxt_state = RAMP_UP;
        duty_d    = lo_q;
      end else begin
        nxt_state   = IDLE;
        duty_d      = '0;
        stop_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= IDLE;
      duty_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      hold_cnt_q  <= 8'd0;
    end else begin
      cur_state   <= nxt_state;
      duty_q      <= duty_d;
      busy_q      <= (nxt_state != IDLE);
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Envelope configuration is captured once per start and held while busy.
  always_ff @(posedge clk) begin
    if (latch_cfg) begin
      lo_q   <= minDuty;
      hi_q   <= (maxDuty > minDuty) ? maxDuty : minDuty;
      step_q <= (stepSize == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : stepSize;
      hold_q <= holdTicks;
    end
  end

  assign dutyCycle = duty_q;
  assign busy      = busy_q;
  assign cycleDone = done_q;
  assign state     = cur_state;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: table-driven envelopes, hand-written
// corner sequences and randomized configurations against an arithmetic model.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, stepPulse, start, stop, loop;
  logic [7:0] minDuty, maxDuty, stepSize, holdTicks;
  logic [7:0] dutyCycle;
  logic       busy, cycleDone;
  logic [2:0] state;

  pwm_fade_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .stepPulse(stepPulse),
    .start(start), .stop(stop), .loop(loop),
    .minDuty(minDuty), .maxDuty(maxDuty), .stepSize(stepSize), .holdTicks(holdTicks),
    .dutyCycle(dutyCycle), .busy(busy), .cycleDone(cycleDone), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int got[$];
  int exp_q[$];
  int m_lo, m_hi, m_st, m_hd;

  typedef struct {
    int mn, mx, st, hd;
    int ticks, peak, peak_tick;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock with stepPulse driven; inputs change and outputs are sampled 1ns after posedge.
  task automatic clk_cycle(input logic sp);
    stepPulse = sp;
    @(posedge clk);
    #1;
    stepPulse = 1'b0;
  endtask

  // Expected duty after each tick of one cycle, derived from the envelope rules.
  function automatic void build_model(input bit lp);
    int n;
    exp_q.delete();
    n = (m_hi == m_lo) ? 1 : (m_hi - m_lo + m_st - 1) / m_st;
    for (int k = 1; k <= n; k++) begin
      int v;
      v = m_lo + k * m_st;
      exp_q.push_back((v > m_hi) ? m_hi : v);
    end
    repeat (m_hd) exp_q.push_back(m_hi);
    for (int k = 1; k <= n; k++) begin
      int v;
      v = m_hi - k * m_st;
      exp_q.push_back((v < m_lo) ? m_lo : v);
    end
    repeat (m_hd) exp_q.push_back(m_lo);
    exp_q[exp_q.size() - 1] = lp ? m_lo : 0;
  endfunction

  // Runs one envelope cycle with random tick spacing (some gaps frozen with enable=0
  // while stepPulse is high). stop_at >= 0 pulses stop after that many ticks.
  task automatic run_cycle(input bit do_start, input int stop_at, input int maxgap);
    bit done;
    bit lp;
    done = 1'b0;
    got.delete();
    if (do_start) begin
      m_lo = int'(minDuty);
      m_hi = (maxDuty > minDuty) ? int'(maxDuty) : int'(minDuty);
      m_st = (stepSize == 8'd0) ? 1 : int'(stepSize);
      m_hd = int'(holdTicks);
      start = 1'b1;
      clk_cycle(1'b0);
      start = 1'b0;
      chk("start_duty", int'(dutyCycle), m_lo);
      chk("start_busy", int'(busy), 1);
    end
    for (int t = 0; t < 3000 && !done; t++) begin
      int g;
      g = int'($urandom_range(maxgap, 0));
      repeat (g) begin
        if ($urandom_range(1, 0) == 1) begin
          enable = 1'b0;
          clk_cycle(1'b1);
          enable = 1'b1;
        end else begin
          clk_cycle(1'b0);
        end
      end
      if (got.size() == stop_at) begin
        stop = 1'b1;
        clk_cycle(1'b0);
        stop = 1'b0;
      end
      clk_cycle(1'b1);
      got.push_back(int'(dutyCycle));
      done = cycleDone;
    end
    chk("cycle_done_seen", int'(done), 1);
    lp = loop && (stop_at < 0) && !stop;
    build_model(lp);
    chk("tick_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("duty_tick%0d", i + 1), got[i], exp_q[i]);
      if (got[i] != exp_q[i]) break;
    end
    clk_cycle(1'b0);
    chk("done_pulse_width", int'(cycleDone), 0);
    if (lp) begin
      chk("loop_state", int'(state), 1);
      chk("loop_duty", int'(dutyCycle), m_lo);
    end else begin
      chk("end_busy", int'(busy), 0);
      chk("end_state", int'(state), 0);
      chk("end_duty", int'(dutyCycle), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_exp[10];
    sat_exp = '{110, 210, 250, 250, 250, 150, 50, 10, 10, 0};

    vecs[0] = '{0,   255, 1,   0, 510, 255, 255};
    vecs[1] = '{10,  250, 100, 2, 10,  250, 3};
    vecs[2] = '{200, 100, 0,   0, 2,   200, 1};
    vecs[3] = '{50,  50,  5,   3, 8,   50,  1};
    vecs[4] = '{0,   100, 30,  1, 10,  100, 4};
    vecs[5] = '{255, 255, 255, 0, 2,   255, 1};
    vecs[6] = '{0,   255, 255, 0, 2,   255, 1};
    vecs[7] = '{1,   254, 200, 1, 6,   254, 2};

    rst = 1'b1; enable = 1'b1; stepPulse = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    minDuty = 8'd0; maxDuty = 8'd0; stepSize = 8'd0; holdTicks = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_duty", int'(dutyCycle), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_done", int'(cycleDone), 0);
    rst = 1'b0;
    clk_cycle(1'b1);
    chk("idle_tick_state", int'(state), 0);

    // Table-driven single cycles
    for (int i = 0; i < 8; i++) begin
      int pk, pt;
      minDuty   = 8'(vecs[i].mn);
      maxDuty   = 8'(vecs[i].mx);
      stepSize  = 8'(vecs[i].st);
      holdTicks = 8'(vecs[i].hd);
      run_cycle(1'b1, -1, 3);
      pk = 0; pt = 0;
      foreach (got[j]) if (got[j] > pk) begin pk = got[j]; pt = j + 1; end
      chk($sformatf("vec%0d_ticks", i), got.size(), vecs[i].ticks);
      chk($sformatf("vec%0d_peak", i), pk, vecs[i].peak);
      chk($sformatf("vec%0d_peak_tick", i), pt, vecs[i].peak_tick);
      if (i == 1) begin
        for (int k = 0; k < 10 && k < got.size(); k++)
          chk($sformatf("sat_seq%0d", k), got[k], sat_exp[k]);
      end
    end

    // Loop with stop requested mid ramp-up of the second cycle
    minDuty = 8'd20; maxDuty = 8'd120; stepSize = 8'd25; holdTicks = 8'd1;
    loop = 1'b1;
    run_cycle(1'b1, -1, 1);
    run_cycle(1'b0, 2, 1);
    repeat (10) clk_cycle(1'b1);
    chk("after_stop_state", int'(state), 0);
    chk("after_stop_duty", int'(dutyCycle), 0);

    // start and stop together in IDLE with loop set: exactly one cycle
    stop = 1'b1;
    run_cycle(1'b1, -1, 1);
    stop = 1'b0;
    loop = 1'b0;

    // Enable freeze during RAMP_DOWN with stepPulse held high
    minDuty = 8'd0; maxDuty = 8'd200; stepSize = 8'd10; holdTicks = 8'd0;
    start = 1'b1;
    clk_cycle(1'b0);
    start = 1'b0;
    repeat (23) clk_cycle(1'b1);
    chk("freeze_pre_duty", int'(dutyCycle), 170);
    chk("freeze_pre_state", int'(state), 3);
    enable = 1'b0;
    for (int k = 0; k < 50; k++) begin
      clk_cycle(1'b1);
      chk("freeze_duty", int'(dutyCycle), 170);
      chk("freeze_state", int'(state), 3);
    end
    enable = 1'b1;
    clk_cycle(1'b1);
    chk("resume_duty", int'(dutyCycle), 160);
    repeat (16) clk_cycle(1'b1);
    chk("freeze_cycle_done", int'(cycleDone), 1);
    chk("freeze_end_busy", int'(busy), 0);

    // Asynchronous reset in HOLD_HIGH, observed before the next clock edge
    minDuty = 8'd10; maxDuty = 8'd250; stepSize = 8'd100; holdTicks = 8'd5;
    start = 1'b1;
    clk_cycle(1'b0);
    start = 1'b0;
    repeat (4) clk_cycle(1'b1);
    chk("hold_state", int'(state), 2);
    chk("hold_duty", int'(dutyCycle), 250);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_duty", int'(dutyCycle), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_done", int'(cycleDone), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // start while busy must not restart or re-latch configuration
    start = 1'b1;
    clk_cycle(1'b0);
    start = 1'b0;
    chk("restart_duty", int'(dutyCycle), 10);
    clk_cycle(1'b1);
    chk("busy_step1", int'(dutyCycle), 110);
    minDuty = 8'd0; stepSize = 8'd1;
    start = 1'b1;
    clk_cycle(1'b0);
    start = 1'b0;
    chk("busy_start_ignored_duty", int'(dutyCycle), 110);
    chk("busy_start_ignored_state", int'(state), 1);
    clk_cycle(1'b1);
    chk("busy_step2", int'(dutyCycle), 210);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized configurations against the model
    for (int r = 0; r < 6; r++) begin
      minDuty   = 8'($urandom_range(255, 0));
      maxDuty   = 8'($urandom_range(255, 0));
      stepSize  = 8'($urandom_range(40, 0));
      holdTicks = 8'($urandom_range(4, 0));
      run_cycle(1'b1, -1, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
